// File: rtl/fxp_pkg.sv
// Fixed-point helpers shared by the LPC datapath blocks.
//   calc_t        : wide signed scratch type for generic Q-format arithmetic
//   clamp_t       : {sat, clamped value} result of sat_clamp()
//   qmax/qmin     : largest / smallest signed Q1.(width-1) value as calc_t
//   sat_clamp     : clamp a calc_t into a signed width-bit range, flag if clamped
//   round_half_up : arithmetic right shift by frac bits, ties rounded upwards
package fxp_pkg;

    localparam int CALC_W = 128;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        logic  sat;
        calc_t value;
    } clamp_t;

    function automatic calc_t qmax(input int width);
        return (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t qmin(input int width);
        return -(calc_t'(1) <<< (width - 1));
    endfunction

    function automatic clamp_t sat_clamp(input calc_t value, input int width);
        clamp_t res;
        res.sat   = 1'b0;
        res.value = value;
        if (value > qmax(width)) begin
            res.sat   = 1'b1;
            res.value = qmax(width);
        end else if (value < qmin(width)) begin
            res.sat   = 1'b1;
            res.value = qmin(width);
        end
        return res;
    endfunction

    // Adding half an LSB before the floor shift gives round-half-up for both
    // signs (-0.75 -> -1, -0.5 -> 0, +0.5 -> +1).
    function automatic calc_t round_half_up(input calc_t value, input int frac);
        if (frac <= 0)
            return value;
        return (value + (calc_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// Combinational signed saturating narrower: IN_WID-bit signed value to
// OUT_W-bit signed result. Shared by the scaler and later LPC stages.
//   value : signed input, IN_WID bits
//   data  : clamped result, OUT_W bits
//   sat   : 1 when value was outside the OUT_W range and got clamped
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int IN_WID = 48,
    parameter int OUT_W  = 32
) (
    input  logic signed [IN_WID-1:0] value,
    output logic        [OUT_W-1:0]  data,
    output logic                     sat
);

    generate
        if (IN_WID <= OUT_W) begin : g_wide
            // Output already covers every input value: pure sign extension.
            assign data = OUT_W'(value);
            assign sat  = 1'b0;
        end else begin : g_clamp
            localparam logic signed [IN_WID-1:0] QMAX = IN_WID'(qmax(OUT_W));
            localparam logic signed [IN_WID-1:0] QMIN = IN_WID'(qmin(OUT_W));

            always_comb begin
                data = value[OUT_W-1:0];
                sat  = 1'b0;
                if (value > QMAX) begin
                    data = QMAX[OUT_W-1:0];
                    sat  = 1'b1;
                end else if (value < QMIN) begin
                    data = QMIN[OUT_W-1:0];
                    sat  = 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fxp_scale_sat.sv
// Streaming fixed-point scaler: widens Q1.(IN_W-1) samples to Q1.(OUT_W-1),
// multiplies by a signed per-sample gain, applies a per-sample left shift,
// rounds (when the gain has fractional bits) and saturates instead of wrapping.
// Two register stages; a sample accepted at edge N is presented after edge
// N+1 and transfers out at edge N+2 when out_ready is high.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready is combinational)
//   in_data/in_gain/in_shl: sample, gain and shift, captured together
//   out_valid/out_ready   : output handshake
//   out_data/out_sat      : saturated result and its per-sample clamp flag
//   sat_sticky/clr_sat    : sticky saturation flag and its synchronous clear
module fxp_scale_sat
    import fxp_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int GAIN_W    = 16,
    parameter int GAIN_FRAC = 0,
    parameter int SHIFT_W   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    input  logic signed [GAIN_W-1:0]  in_gain,
    input  logic        [SHIFT_W-1:0] in_shl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic                      sat_sticky,
    input  logic                      clr_sat
);

    localparam int P_W = IN_W + GAIN_W;              // full product
    localparam int A_W = P_W + OUT_W - IN_W;         // product after alignment
    localparam int S_W = A_W + (1 << SHIFT_W) - 1;   // holds the largest shift exactly

    logic [2:1]               vld_pipe;
    logic                     en;
    logic signed [P_W-1:0]    s1_p;
    logic [SHIFT_W-1:0]       s1_shl;
    logic signed [A_W-1:0]    a;
    logic signed [A_W-1:0]    r;
    logic signed [S_W-1:0]    s;
    logic [OUT_W-1:0]         sat_data;
    logic                     sat_flag;

    // Single global stall: everything advances only when the output slot is
    // free or being drained this cycle.
    assign en        = !vld_pipe[2] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[2];

    // Stage 2 datapath. r cannot exceed A_W bits: rounding adds half an LSB
    // and then drops GAIN_FRAC bits, so the extra carry is always shifted out.
    always_comb begin
        a = A_W'(s1_p) <<< (OUT_W - IN_W);
        r = A_W'(round_half_up(calc_t'(a), GAIN_FRAC));
        s = S_W'(r) <<< s1_shl;
    end

    fxp_sat #(
        .IN_WID (S_W),
        .OUT_W  (OUT_W)
    ) u_sat (
        .value (s),
        .data  (sat_data),
        .sat   (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_p     <= '0;
            s1_shl   <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[1], in_valid};
            // Data registers only load on a real sample so idle cycles leave them untouched.
            if (in_valid) begin
                s1_p   <= P_W'(in_data) * P_W'(in_gain);
                s1_shl <= in_shl;
            end
            if (vld_pipe[1]) begin
                out_data <= sat_data;
                out_sat  <= sat_flag;
            end
        end
    end

    // A saturated result leaving the block in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && out_sat)
            sat_sticky <= 1'b1;
        else if (clr_sat)
            sat_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_fxp_scale_sat.sv
module tb_fxp_scale_sat;

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic               in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic signed [15:0] in_data = '0, in_gain = '0;
    logic        [4:0]  in_shl = '0;
    logic        [31:0] out_data;
    logic               out_sat, sat_sticky, clr_sat = 1'b0;

    // rounding instance: Q1.15 -> Q1.15, gain with 2 fractional bits
    logic               r_in_valid = 1'b0, r_in_ready, r_out_valid, r_out_ready = 1'b1;
    logic signed [15:0] r_in_data = '0, r_in_gain = '0;
    logic        [4:0]  r_in_shl = '0;
    logic        [15:0] r_out_data;
    logic               r_out_sat, r_sat_sticky, r_clr_sat = 1'b0;

    fxp_scale_sat dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_gain(in_gain), .in_shl(in_shl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .sat_sticky(sat_sticky), .clr_sat(clr_sat)
    );

    fxp_scale_sat #(.IN_W(16), .OUT_W(16), .GAIN_W(16), .GAIN_FRAC(2), .SHIFT_W(5)) dut_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .in_gain(r_in_gain), .in_shl(r_in_shl),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
        .out_sat(r_out_sat), .sat_sticky(r_sat_sticky), .clr_sat(r_clr_sat)
    );

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int out_cnt = 0, r_out_cnt = 0;
    int last_acc = 0, last_out_edge = 0;
    logic [31:0] last_data = '0;
    logic        last_sat = 1'b0;
    logic [15:0] r_last_data = '0;
    bit   chk_en_on = 1'b0;
    int   or_mode = 0;
    exp_t exp_q[$];
    exp_t r_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact integer arithmetic, floor-based rounding, then clamp.
    function automatic exp_t ref_model(input int d, input int g, input int shl,
                                       input int in_w, input int out_w, input int gf);
        logic signed [127:0] v, one, den, num, q, hi, lo;
        exp_t e;
        one = 1;
        v = d;
        v = v * g;
        v = v * (one <<< (out_w - in_w));
        if (gf > 0) begin
            den = one <<< gf;
            num = v + (den >>> 1);
            q = num / den;
            if ((num % den) != 0 && num < 0) q = q - one;
            v = q;
        end
        v = v * (one <<< shl);
        hi = (one <<< (out_w - 1)) - one;
        lo = -(one <<< (out_w - 1));
        e.sat = 1'b0;
        if (v > hi) begin v = hi; e.sat = 1'b1; end
        else if (v < lo) begin v = lo; e.sat = 1'b1; end
        e.val = 64'(v);
        return e;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // main instance scoreboard: push on input transfer, pop on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(in_data, in_gain, int'(in_shl), 16, 32, 0));
            if (out_valid && out_ready) begin
                out_cnt++;
                last_data = out_data;
                last_sat = out_sat;
                last_out_edge = cyc + 1;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL main_unexpected_output: got 0x%0h with nothing expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== 32'(e.val) || out_sat !== e.sat) begin
                        n_err++;
                        $display("FAIL main_result: got 0x%0h sat=%0b expected 0x%0h sat=%0b",
                                 out_data, out_sat, 32'(e.val), e.sat);
                    end
                end
            end
            if (chk_en_on) begin
                n_vec++;
                if (in_ready !== (!out_valid || out_ready)) begin
                    n_err++;
                    $display("FAIL in_ready_en: got %0b expected %0b", in_ready, !out_valid || out_ready);
                end
            end
        end
    end

    // rounding instance scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (r_in_valid && r_in_ready)
                r_q.push_back(ref_model(r_in_data, r_in_gain, int'(r_in_shl), 16, 16, 2));
            if (r_out_valid && r_out_ready) begin
                r_out_cnt++;
                r_last_data = r_out_data;
                n_vec++;
                if (r_q.size() == 0) begin
                    n_err++;
                    $display("FAIL round_unexpected_output: got 0x%0h with nothing expected", r_out_data);
                end else begin
                    e = r_q.pop_front();
                    if (r_out_data !== 16'(e.val) || r_out_sat !== e.sat) begin
                        n_err++;
                        $display("FAIL round_result: got 0x%0h sat=%0b expected 0x%0h sat=%0b",
                                 r_out_data, r_out_sat, 16'(e.val), e.sat);
                    end
                end
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                1: begin out_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
                2: out_ready = ($urandom % 3) != 0;
                default: begin out_ready = 1'b1; k = 0; end
            endcase
        end
    end

    task automatic send(input logic [15:0] d, input logic [15:0] g, input logic [4:0] s);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_gain = g; in_shl = s;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
        end
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_r(input logic [15:0] d, input logic [15:0] g, input logic [4:0] s);
        int n = 0;
        bit acc = 1'b0;
        r_in_valid = 1'b1; r_in_data = d; r_in_gain = g; r_in_shl = s;
        do begin
            @(negedge clk); acc = r_in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL send_r_timeout: r_in_ready stayed %0b, expected 1", r_in_ready);
        end
        r_in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int n = 0;
        while (out_cnt < target && n < 200) begin
            @(posedge clk); #2; n++;
        end
        if (out_cnt < target) begin
            n_vec++; n_err++;
            $display("FAIL wait_out_timeout: got %0d outputs expected %0d", out_cnt, target);
        end
    endtask

    task automatic wait_r_out(input int target);
        int n = 0;
        while (r_out_cnt < target && n < 200) begin
            @(posedge clk); #2; n++;
        end
        if (r_out_cnt < target) begin
            n_vec++; n_err++;
            $display("FAIL wait_r_out_timeout: got %0d outputs expected %0d", r_out_cnt, target);
        end
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom % 6)
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'($urandom % 9);
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [4:0] pick_shl();
        if ($urandom % 2) return 5'($urandom % 4);
        return 5'($urandom % 32);
    endfunction

    function automatic logic [15:0] pick_gain();
        if ($urandom % 3 == 0) return pick16();
        return 16'(int'($urandom % 7) - 3);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sat", out_sat, 0);
        chk("reset_sat_sticky", sat_sticky, 0);
        rst_n = 1'b1;

        // widening and latency
        base = out_cnt; send(16'd1, 16'd1, 5'd0); wait_out(base + 1);
        chk("widen_pos", last_data, 32'h0001_0000);
        chk("widen_pos_sat", last_sat, 0);
        chk("latency", last_out_edge - last_acc, 2);
        base = out_cnt; send(16'hFFFF, 16'd1, 5'd0); wait_out(base + 1);
        chk("widen_neg", last_data, 32'hFFFF_0000);

        // negative gain, exact most-negative value is not flagged
        base = out_cnt; send(16'hFFFF, 16'hFFFE, 5'd0); wait_out(base + 1);
        chk("neg_gain", last_data, 32'h0002_0000);
        base = out_cnt; send(16'h4000, 16'hFFFE, 5'd0); wait_out(base + 1);
        chk("qmin_exact", last_data, 32'h8000_0000);
        chk("qmin_exact_sat", last_sat, 0);
        chk("sticky_still_clear", sat_sticky, 0);

        // saturation and sticky flag
        base = out_cnt; send(16'h8000, 16'hFFFF, 5'd0); wait_out(base + 1);
        chk("sat_pos", last_data, 32'h7FFF_FFFF);
        chk("sat_pos_flag", last_sat, 1);
        chk("sticky_set", sat_sticky, 1);
        base = out_cnt; send(16'h7FFF, 16'd1, 5'd1); wait_out(base + 1);
        chk("sat_shift", last_data, 32'h7FFF_FFFF);
        chk("sat_shift_flag", last_sat, 1);
        @(negedge clk); clr_sat = 1'b1;
        @(posedge clk); #1; clr_sat = 1'b0;
        chk("sticky_clear", sat_sticky, 0);
        send(16'h8000, 16'hFFFF, 5'd0);
        @(negedge clk);
        @(negedge clk); clr_sat = 1'b1;
        chk("sat_transfer_due", out_valid && out_ready && out_sat, 1);
        @(posedge clk); #1; clr_sat = 1'b0;
        chk("sticky_set_wins", sat_sticky, 1);

        // backpressure
        repeat (2) @(posedge clk);
        #1;
        base = out_cnt;
        or_mode = 1;
        chk_en_on = 1'b1;
        for (int i = 0; i < 8; i++) send(pick16(), pick_gain(), pick_shl());
        wait_out(base + 8);
        chk_en_on = 1'b0;
        or_mode = 0;
        chk("bp_count", out_cnt - base, 8);
        chk("bp_queue_empty", exp_q.size(), 0);

        // reset with two samples in flight
        base = out_cnt; send(16'h8000, 16'hFFFF, 5'd0); wait_out(base + 1);
        chk("pre_reset_sticky", sat_sticky, 1);
        send(16'd7, 16'd3, 5'd1);
        send(16'd9, 16'hFFFD, 5'd2);
        rst_n = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        chk("reset_async_sticky", sat_sticky, 0);
        exp_q.delete();
        base = out_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_partial", out_cnt - base, 0);
        send(16'd5, 16'd3, 5'd2); wait_out(base + 1);
        chk("reset_latency", last_out_edge - last_acc, 2);
        chk("reset_value", last_data, 32'h003C_0000);

        // random traffic with random backpressure
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 4 == 0) begin @(posedge clk); #1; end
            send(pick16(), pick_gain(), pick_shl());
        end
        or_mode = 0;
        base = 0;
        while (exp_q.size() != 0 && base < 200) begin @(posedge clk); #2; base++; end
        chk("drain_main", exp_q.size(), 0);

        // rounding instance
        base = r_out_cnt; send_r(16'd3, 16'd2, 5'd0); wait_r_out(base + 1);
        chk("round_3", r_last_data, 16'd2);
        base = r_out_cnt; send_r(16'hFFFD, 16'd2, 5'd0); wait_r_out(base + 1);
        chk("round_m3", r_last_data, 16'hFFFF);
        base = r_out_cnt; send_r(16'd2, 16'd2, 5'd0); wait_r_out(base + 1);
        chk("round_2", r_last_data, 16'd1);
        for (int i = 0; i < 100; i++) send_r(pick16(), pick_gain(), pick_shl());
        base = 0;
        while (r_q.size() != 0 && base < 200) begin @(posedge clk); #2; base++; end
        chk("drain_round", r_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
